// File: rtl/counter_cfg_ctrl.sv
// Shadow/active configuration controller for the PWM timebase counter.
// Shadows are committed atomically at a terminal value, on FORCE, or at once when stopped.
module counter_cfg_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [2:0]  rd_addr,
  output logic [15:0] rd_data,
  input  logic [15:0] count_val,
  output logic [15:0] period,
  output logic [7:0]  prescale,
  output logic        upnotdown,
  output logic        en,
  output logic        count_reset,
  output logic        update_pending
);

  localparam logic [1:0] ST_STOPPED = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;
  localparam logic [1:0] ST_COMMIT  = 2'd3;

  localparam logic [2:0] A_PERIOD   = 3'd0;
  localparam logic [2:0] A_PRESCALE = 3'd1;
  localparam logic [2:0] A_CTRL     = 3'd2;
  localparam logic [2:0] A_CMD      = 3'd3;
  localparam logic [2:0] A_STATUS   = 3'd4;

  logic [15:0] sh_period_q, sh_period_d;
  logic [7:0]  sh_prescale_q, sh_prescale_d;
  logic        sh_en_q, sh_en_d;
  logic        sh_up_q, sh_up_d;
  logic        pending_q, pending_d;
  logic        force_q, force_d;
  logic [15:0] period_q, period_d;
  logic [7:0]  prescale_q, prescale_d;
  logic        up_q, up_d;
  logic        en_q, en_d;
  logic        count_reset_q, count_reset_d;
  logic [1:0]  state_q, state_d;
  logic [15:0] rd_data_q, rd_data_d;

  logic wr_cfg;
  logic wr_cmd;
  logic tv;
  logic commit;

  always_comb begin
    wr_cfg = wr_en && (wr_addr <= A_CTRL);
    wr_cmd = wr_en && (wr_addr == A_CMD);
    tv     = up_q ? (count_val == period_q) : (count_val == 16'd0);
    commit = force_q
          || ((state_q == ST_STOPPED) && pending_q)
          || ((state_q == ST_PENDING) && tv);

    // Commit takes the pre-write shadows; a write on the same edge lands afterwards.
    period_d   = commit ? sh_period_q   : period_q;
    prescale_d = commit ? sh_prescale_q : prescale_q;
    up_d       = commit ? sh_up_q       : up_q;
    en_d       = commit ? sh_en_q       : en_q;

    sh_period_d   = sh_period_q;
    sh_prescale_d = sh_prescale_q;
    sh_en_d       = sh_en_q;
    sh_up_d       = sh_up_q;
    if (wr_en) begin
      case (wr_addr)
        A_PERIOD:   sh_period_d = wr_data;
        A_PRESCALE: sh_prescale_d = wr_data[7:0];
        A_CTRL: begin
          sh_en_d = wr_data[0];
          sh_up_d = wr_data[1];
        end
        default: ;
      endcase
    end

    pending_d = (pending_q && !commit) || wr_cfg;
    // A stop request is never deferred to a boundary.
    force_d = (wr_cmd && wr_data[0]) || (wr_en && (wr_addr == A_CTRL) && !wr_data[0]);
    count_reset_d = commit || (wr_cmd && wr_data[1] && !wr_data[0]);

    state_d = state_q;
    if (commit) begin
      state_d = ST_COMMIT;
    end else begin
      case (state_q)
        ST_STOPPED: state_d = ST_STOPPED;
        ST_RUNNING: state_d = wr_cfg ? ST_PENDING : ST_RUNNING;
        ST_PENDING: state_d = ST_PENDING;
        default:    state_d = en_q ? (pending_d ? ST_PENDING : ST_RUNNING) : ST_STOPPED;
      endcase
    end

    case (rd_addr)
      A_PERIOD:   rd_data_d = sh_period_d;
      A_PRESCALE: rd_data_d = {8'd0, sh_prescale_d};
      A_CTRL:     rd_data_d = {14'd0, sh_up_d, sh_en_d};
      A_STATUS:   rd_data_d = {12'd0, state_d, en_d, pending_d};
      default:    rd_data_d = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_period_q   <= 16'hFFFF;
      sh_prescale_q <= 8'd0;
      sh_en_q       <= 1'b0;
      sh_up_q       <= 1'b1;
      pending_q     <= 1'b0;
      force_q       <= 1'b0;
      period_q      <= 16'hFFFF;
      prescale_q    <= 8'd0;
      up_q          <= 1'b1;
      en_q          <= 1'b0;
      count_reset_q <= 1'b0;
      state_q       <= ST_STOPPED;
      rd_data_q     <= 16'd0;
    end else begin
      sh_period_q   <= sh_period_d;
      sh_prescale_q <= sh_prescale_d;
      sh_en_q       <= sh_en_d;
      sh_up_q       <= sh_up_d;
      pending_q     <= pending_d;
      force_q       <= force_d;
      period_q      <= period_d;
      prescale_q    <= prescale_d;
      up_q          <= up_d;
      en_q          <= en_d;
      count_reset_q <= count_reset_d;
      state_q       <= state_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign rd_data        = rd_data_q;
  assign period         = period_q;
  assign prescale       = prescale_q;
  assign upnotdown      = up_q;
  assign en             = en_q;
  assign count_reset    = count_reset_q;
  assign update_pending = pending_q;

endmodule
